// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, divisor record and minimum divisor for the UART baud generator
package uart_pkg;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_W_DEFAULT = 16;
  localparam int FRAC_W_DEFAULT = 4;
  localparam int DIV_MIN = 2;
  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0]  div_int;
    logic [FRAC_W_DEFAULT-1:0] div_frac;
  } divisor_t;
endpackage

// File: rtl/uart_frac_accum.sv
// uart_frac_accum: fractional-divisor accumulator; carry stretches the current period by one clock
module uart_frac_accum
  import uart_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic              physical_clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  assign sum   = {1'b0, clr ? FRAC_W'(0) : acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];
  always_ff @(posedge physical_clock or negedge reset_n)
    if (!reset_n) acc <= '0;
    else if (step) acc <= sum[FRAC_W-1:0];
    else if (clr) acc <= '0;
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable int+frac baud generator producing rx_tick, tx_tick and uart_clock.
// Define UART_BAUD_GEN_FRAC_EN to enable the fractional accumulator; otherwise div_frac is ignored.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEFAULT,
  parameter int FRAC_W     = FRAC_W_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic              physical_clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              rx_tick,
  output logic              tx_tick,
  output logic              uart_clock,
  output logic              div_pending,
  output logic              div_err
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  typedef struct packed {
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } div_t;
  div_t pend, act, eff;
  logic [DIV_W-1:0] cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [DIV_W:0]   period;
  logic run, apply, reload, clamp, carry;
  assign tx_tick = rx_tick && os_cnt == OS_W'(OVERSAMPLE - 1);
  // The period starting on an apply edge already uses the new divisor.
  always_comb begin
    apply  = div_pending && (!enable || tx_tick);
    clamp  = pend.div_int < DIV_W'(DIV_MIN);
    eff    = apply ? {clamp ? DIV_W'(DIV_MIN) : pend.div_int, pend.div_frac} : act;
    reload = enable && (!run || cnt == '0);
    period = {1'b0, eff.div_int} + {{DIV_W{1'b0}}, carry};
  end
`ifdef UART_BAUD_GEN_FRAC_EN
  uart_frac_accum #(.FRAC_W(FRAC_W)) u_frac (
    .physical_clock(physical_clock),
    .reset_n       (reset_n),
    .clr           (apply || !enable),
    .step          (reload),
    .frac          (eff.div_frac),
    .carry         (carry)
  );
`else
  logic unused_frac;
  assign carry       = 1'b0;
  assign unused_frac = ^eff.div_frac;
`endif
  always_ff @(posedge physical_clock or negedge reset_n)
    if (!reset_n) begin
      run         <= 1'b0;
      cnt         <= DIV_W'(1);
      os_cnt      <= '0;
      rx_tick     <= 1'b0;
      uart_clock  <= 1'b0;
      pend        <= '0;
      act         <= {DIV_W'(DIV_MIN), FRAC_W'(0)};
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      run         <= enable;
      cnt         <= !enable ? DIV_W'(1) : reload ? DIV_W'(period - 1'b1) : cnt - 1'b1;
      rx_tick     <= enable && run && cnt == DIV_W'(1);
      os_cnt      <= !enable ? '0 : !rx_tick ? os_cnt : tx_tick ? '0 : os_cnt + 1'b1;
      uart_clock  <= enable && !tx_tick && (uart_clock || (rx_tick && os_cnt == OS_W'(OVERSAMPLE / 2 - 1)));
      div_pending <= div_load || (div_pending && !apply);
      if (div_load) pend <= {div_int, div_frac};
      if (apply) begin
        act     <= eff;
        div_err <= clamp;
      end
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen (default and FRAC_EN builds)
module tb_uart_baud_gen;
  logic        physical_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        rx_tick, tx_tick, uart_clock, div_pending, div_err;
  int          tests = 0;
  int          fails = 0;

  uart_baud_gen dut (
    .physical_clock(physical_clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .div_int       (div_int),
    .div_frac      (div_frac),
    .div_load      (div_load),
    .rx_tick       (rx_tick),
    .tx_tick       (tx_tick),
    .uart_clock    (uart_clock),
    .div_pending   (div_pending),
    .div_err       (div_err)
  );

  always #5 physical_clock = ~physical_clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge physical_clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_rx(output int n, input int limit = 300);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rx_tick && n < limit);
  endtask

  task automatic wait_tx(output int found, input int limit = 300);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!tx_tick && n < limit);
    found = int'(tx_tick);
  endtask

  task automatic wait_uclk(output int found, input int limit = 300);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!uart_clock && n < limit);
    found = int'(uart_clock);
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  initial begin
    int n, f, hi, rxc, txc, txpos;
    tick(2);
    chk("rst_rx", int'(rx_tick), 0);
    chk("rst_tx", int'(tx_tick), 0);
    chk("rst_uclk", int'(uart_clock), 0);
    chk("rst_pend", int'(div_pending), 0);
    chk("rst_err", int'(div_err), 0);
    reset_n = 1'b1;
    tick();
    load(4, 0);
    chk("load_pend", int'(div_pending), 1);
    tick();
    chk("idle_apply", int'(div_pending), 0);
    enable = 1'b1;
    wait_rx(n);
    chk("d4_latency", n, 4);
    wait_rx(n);
    chk("d4_period", n, 4);
    wait_tx(f);
    chk("d4_tx_found", f, 1);
    hi = 0; rxc = 0; txc = 0; txpos = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      hi += int'(uart_clock);
      rxc += int'(rx_tick);
      if (tx_tick) begin
        txc++;
        txpos = i;
      end
    end
    chk("d4_uclk_high", hi, 32);
    chk("d4_rx_per_bit", rxc, 16);
    chk("d4_tx_count", txc, 1);
    chk("d4_tx_period", txpos, 64);

    enable = 1'b0;
    load(1, 0);
    tick();
    chk("clamp_err", int'(div_err), 1);
    chk("clamp_pend", int'(div_pending), 0);
    enable = 1'b1;
    wait_rx(n);
    chk("clamp_latency", n, 2);
    wait_rx(n);
    chk("clamp_period", n, 2);
    load(10, 0);
    chk("d10_pend", int'(div_pending), 1);
    wait_tx(f);
    chk("d10_tx_found", f, 1);
    wait_rx(n);
    chk("d10_first", n, 10);
    chk("d10_err_clear", int'(div_err), 0);
    chk("d10_pend_clear", int'(div_pending), 0);

    enable = 1'b0;
    load(4, 0);
    tick();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) wait_rx(n);
    chk("mid_d4_period", n, 4);
    load(8, 0);
    chk("mid_pend", int'(div_pending), 1);
    wait_tx(f);
    chk("mid_tx_found", f, 1);
    chk("mid_pend_at_tx", int'(div_pending), 1);
    wait_rx(n);
    chk("mid_d8_first", n, 8);
    chk("mid_pend_clear", int'(div_pending), 0);
    wait_rx(n);
    chk("mid_d8_period", n, 8);

    wait_uclk(f);
    chk("en_uclk_high", f, 1);
    enable = 1'b0;
    tick();
    chk("en_uclk_low", int'(uart_clock), 0);
    chk("en_rx_stop", int'(rx_tick), 0);
    rxc = 0; hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rxc += int'(rx_tick) + int'(tx_tick);
      hi += int'(uart_clock);
    end
    chk("en_quiet_ticks", rxc, 0);
    chk("en_quiet_uclk", hi, 0);
    enable = 1'b1;
    wait_rx(n);
    chk("reen_latency", n, 8);

    wait_uclk(f);
    chk("rst_uclk_high", f, 1);
    load(5, 0);
    chk("rst_pend_set", int'(div_pending), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_uclk", int'(uart_clock), 0);
    chk("arst_rx", int'(rx_tick), 0);
    chk("arst_pend", int'(div_pending), 0);
    chk("arst_err", int'(div_err), 0);
    @(posedge physical_clock);
    #1 reset_n = 1'b1;
    wait_rx(n);
    chk("arst_div_default", n, 2);
    wait_rx(n);
    chk("arst_period", n, 2);

`ifdef UART_BAUD_GEN_FRAC_EN
    enable = 1'b0;
    load(4, 8);
    tick();
    enable = 1'b1;
    wait_rx(n);
    chk("frac_p0", n, 4);
    wait_rx(n);
    chk("frac_p1", n, 5);
    wait_rx(n);
    chk("frac_p2", n, 4);
    wait_rx(n);
    chk("frac_p3", n, 5);
    wait_tx(f);
    chk("frac_tx_found", f, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_tick && n < 200);
    chk("frac_tx_period", n, 72);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
